mem_pipe_responder: RTL and testbench
=====================================

# mem_pipe_responder

Multi-cycle main-memory responder that services 16-bit word requests from the pipeline's instruction-fetch or data-memory initiator, or from a cache fill controller. Accepts one request per cycle through a valid/ready handshake and returns read data a fixed `LATENCY` cycles later, with the request address echoed back for matching. It replaces the single-cycle memory model when the design moves to realistic memory timing, and it sits directly below the IMEM/DMEM request ports.

## Interface
- `LATENCY`, default 4: cycles from read acceptance to `data_valid`; legal range 1..8.
- `ADDR_WIDTH`, default 16: byte-address width. Word index is `addr[ADDR_WIDTH-1:1]`.
- `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
- `rst`, input, 1 bit: reset, synchronous and active-high.
- `enable`, input, 1 bit: request valid.
- `wr`, input, 1 bit: 1 = write request, 0 = read request; qualified by `enable`.
- `addr`, input, `ADDR_WIDTH` bits: byte address; `addr[0]` is ignored.
- `data_in`, input, 16 bits: write data.
- `ready`, output, 1 bit: request can be accepted this cycle.
- `data_valid`, output, 1 bit: read response valid this cycle (one-cycle pulse per read).
- `data_out`, output, 16 bits: read data; 0 when `data_valid` = 0.
- `resp_addr`, output, `ADDR_WIDTH` bits: byte address of the read being returned, with bit 0 forced to 0; 0 when `data_valid` = 0.

## Operation
- **Storage:** 2^(`ADDR_WIDTH`-1) words of 16 bits. Reset does not alter storage.
- **Handshake:** a request is accepted on a rising edge where `enable & ready & ~rst`.
  - The initiator holds `addr`, `wr` and `data_in` stable until acceptance.
  - `enable` with `ready` = 0 is ignored; no state changes.
- **Write:** the array is updated at the accepting edge. No response is produced.
- **Read:**
  - The array word is sampled at the accepting edge, so the read sees all writes accepted on earlier edges.
  - The sampled word and its address enter a `LATENCY`-deep shift pipeline of valid/data/address stages.
  - The pipeline output drives `data_valid`, `data_out` and `resp_addr`.
- **Ordering:** responses are in request order, exactly one per accepted read. A write accepted after a read never changes that read's returned data.
- **Outstanding reads:** up to `LATENCY` reads may be in flight. In the default build, `ready` is constant 1 outside reset.
- **Reset:**
  - All pipeline stages are cleared.
  - In-flight reads are discarded; no response is ever delivered for them.
  - In the cycle after a reset edge: `ready` = 1, `data_valid` = 0, `data_out` = 0, `resp_addr` = 0.
  - A request presented while `rst` = 1 is not accepted.

## Timing
- A read accepted at edge N produces `data_valid` = 1 during the cycle after edge N+`LATENCY`-1.
  - That is, registered outputs are visible `LATENCY` cycles after the acceptance cycle.
  - With `LATENCY` = 1, the data is visible in the cycle immediately following acceptance.
- **Back-to-back reads** on consecutive edges produce `data_valid` on consecutive cycles.
- **Throughput:** 1 request per cycle, with reads and writes intermixed freely.
- **Write-then-read, same address, consecutive edges:** the read returns the new data.
- **Read-then-write, same address, consecutive edges:** the read returns the old data.
- All outputs are registered; there is no combinational path from inputs to outputs.
  - Exception: `ready` under `MEM_BLOCKING_EN`, which is registered state only.

## Configuration
- **`MEM_BLOCKING_EN` defined:** non-pipelined mode, for a single-outstanding-request cache controller.
  - FSM states: IDLE and BUSY.
  - IDLE: `ready` = 1. An accepted read moves to BUSY with a down-counter loaded with `LATENCY`-1.
  - BUSY: `ready` = 0. The counter decrements each cycle; the FSM returns to IDLE on the edge that launches `data_valid`.
  - `ready` therefore rises in the same cycle `data_valid` is high.
  - Writes never leave IDLE.
  - `rst` forces IDLE and clears the counter.
- **`MEM_BLOCKING_EN` undefined:** fully pipelined behaviour as described in Operation; no FSM is present.

## Test plan
- **Reset mid-flight:** with `LATENCY`=4, write 0x1234 to 0x0010, read 0x0010, then assert `rst` 2 cycles after acceptance → no `data_valid` ever appears for that read. Re-reading afterwards returns 0x1234, since storage is preserved.
- **Latency:** write 0xBEEF to 0x0020, then read 0x0020 at edge N → `data_valid`=1 for exactly one cycle after edge N+3, with `data_out`=0xBEEF and `resp_addr`=0x0020.
- **Streaming and `addr[0]`:** write 0xA000+i to 0x0100+2i for i=0..7, then issue 8 back-to-back reads, with the i=3 read using address 0x0107 (odd) → 8 consecutive `data_valid` cycles, in order. The i=3 response has `data_out`=0xA003 and `resp_addr`=0x0106.
- **Hazard ordering:** on consecutive edges, write 0x5555 to 0x0040, read 0x0040, write 0x6666 to 0x0040, read 0x0040 → responses are 0x5555, then 0x6666.
- **Blocking mode (`MEM_BLOCKING_EN`):** hold `enable`=1, `wr`=0 continuously → `ready` pattern is 1,0,0,0,1 repeating, and `data_valid` pulses every 4 cycles.
- **Idle outputs:** with no requests for 10 cycles after reset → `data_valid`=0, `data_out`=0x0000 and `resp_addr`=0x0000 throughout.

Source files
------------

// File: rtl/mem_pipe_responder.sv
// Multi-cycle word memory responder: one request per cycle, reads answered LATENCY cycles later.
// Define MEM_BLOCKING_EN for the single-outstanding-read (IDLE/BUSY) mode.
module mem_pipe_responder #(
    parameter int LATENCY    = 4,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  wr,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [15:0]           data_in,
    output logic                  ready,
    output logic                  data_valid,
    output logic [15:0]           data_out,
    output logic [ADDR_WIDTH-1:0] resp_addr
);

    localparam int WORDS = 1 << (ADDR_WIDTH - 1);

    logic [15:0]           mem [WORDS];
    logic [ADDR_WIDTH-2:0] widx;
    logic                  accept;
    logic                  accept_rd;

    logic                  vld_p  [LATENCY];
    logic [15:0]           data_p [LATENCY];
    logic [ADDR_WIDTH-1:0] addr_p [LATENCY];

    assign widx      = addr[ADDR_WIDTH-1:1];
    assign accept    = enable & ready & ~rst;
    assign accept_rd = accept & ~wr;

    // Only the valid bits are reset; data/address stages are masked at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) vld_p[i] <= 1'b0;
        end else begin
            vld_p[0] <= accept_rd;
            for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept & wr) mem[widx] <= data_in;
        data_p[0] <= mem[widx];
        addr_p[0] <= {addr[ADDR_WIDTH-1:1], 1'b0};
        for (int i = 1; i < LATENCY; i++) begin
            data_p[i] <= data_p[i-1];
            addr_p[i] <= addr_p[i-1];
        end
    end

    assign data_valid = vld_p[LATENCY-1];
    assign data_out   = vld_p[LATENCY-1] ? data_p[LATENCY-1] : 16'h0000;
    assign resp_addr  = vld_p[LATENCY-1] ? addr_p[LATENCY-1] : '0;

`ifdef MEM_BLOCKING_EN
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic [2:0] cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // BUSY ends on the edge that launches data_valid; LATENCY=1 never leaves IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept_rd && (LATENCY > 1)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = 3'(LATENCY - 1);
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 3'd1;
                if (cnt == 3'd1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
    end
`else
    assign ready = 1'b1;
`endif

endmodule

// File: tb/tb_mem_pipe_responder.sv
// Bench for mem_pipe_responder: queue-based reference model compared every cycle, plus literal scenario checks.
module tb_mem_pipe_responder;

    localparam int L  = 4;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [15:0]   data_in = '0;
    logic          ready;
    logic          data_valid;
    logic [15:0]   data_out;
    logic [AW-1:0] resp_addr;

    mem_pipe_responder #(.LATENCY(L), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .ready(ready), .data_valid(data_valid),
        .data_out(data_out), .resp_addr(resp_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [15:0]   d;
        logic [AW-1:0] a;
    } rsp_t;

    int            tests = 0;
    int            fails = 0;
    int            edge_n = 0;
    int            busy_until = 0;
    bit            last_acc = 0;
    logic [15:0]   mm [int];
    rsp_t          q [$];
    logic [15:0]   got_d [$];
    logic [AW-1:0] got_a [$];
    int            got_e [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Advance one clock with the currently driven inputs, update the model, compare outputs.
    task automatic cycle();
        logic rdy_b;
        bit   acc;
        bit   exp_v;
        rsp_t r;
        rdy_b = ready;
        @(posedge clk);
        edge_n++;
        acc = (enable === 1'b1) && (rdy_b === 1'b1) && (rst === 1'b0);
        if (rst) begin
            q.delete();
            busy_until = 0;
        end else if (acc) begin
            if (wr) mm[int'(addr >> 1)] = data_in;
            else begin
                r.due = edge_n + L - 1;
                r.d   = mm[int'(addr >> 1)];
                r.a   = addr & ~AW'(1);
                q.push_back(r);
`ifdef MEM_BLOCKING_EN
                busy_until = edge_n + L - 1;
`endif
            end
        end
        last_acc = acc;
        #1;
        exp_v = (q.size() > 0) && (q[0].due == edge_n);
        check("data_valid", 32'(data_valid), 32'(exp_v));
        check("data_out", 32'(data_out), exp_v ? 32'(q[0].d) : 32'h0);
        check("resp_addr", 32'(resp_addr), exp_v ? 32'(q[0].a) : 32'h0);
`ifdef MEM_BLOCKING_EN
        check("ready", 32'(ready), 32'(edge_n >= busy_until));
`else
        check("ready", 32'(ready), 32'h1);
`endif
        if (exp_v) void'(q.pop_front());
        if (data_valid === 1'b1) begin
            got_d.push_back(data_out);
            got_a.push_back(resp_addr);
            got_e.push_back(edge_n);
        end
    endtask

    task automatic req(input bit w, input logic [AW-1:0] a, input logic [15:0] d);
        int n;
        enable = 1'b1; wr = w; addr = a; data_in = d;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_acc && n < 20);
        if (!last_acc) check("req_accept_timeout", 32'(last_acc), 32'h1);
    endtask

    task automatic idle(input int n);
        enable = 1'b0; wr = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_log();
        got_d.delete(); got_a.delete(); got_e.delete();
    endtask

    int acc_edge;

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_ready", 32'(ready), 32'h1);

        // Idle outputs for 10 cycles after reset
        clear_log();
        idle(10);
        check("idle_no_resp", 32'(got_d.size()), 32'h0);

        // Reset mid-flight
        req(1, 16'h0010, 16'h1234);
        req(0, 16'h0010, 16'h0);
        enable = 1'b0;
        clear_log();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(L + 3);
        check("rst_flight_dropped", 32'(got_d.size()), 32'h0);
        req(0, 16'h0010, 16'h0);
        idle(L + 1);
        check("rst_reread_cnt", 32'(got_d.size()), 32'h1);
        if (got_d.size() > 0) check("rst_reread_data", 32'(got_d[0]), 32'h1234);

        // Latency
        req(1, 16'h0020, 16'hBEEF);
        clear_log();
        req(0, 16'h0020, 16'h0);
        acc_edge = edge_n;
        idle(L + 2);
        check("lat_cnt", 32'(got_d.size()), 32'h1);
        if (got_d.size() > 0) begin
            check("lat_edge", 32'(got_e[0]), 32'(acc_edge + 3));
            check("lat_data", 32'(got_d[0]), 32'hBEEF);
            check("lat_addr", 32'(got_a[0]), 32'h0020);
        end

        // Streaming with an odd address
        for (int i = 0; i < 8; i++) req(1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i));
        clear_log();
        for (int i = 0; i < 8; i++) req(0, (i == 3) ? 16'h0107 : 16'(16'h0100 + 2 * i), 16'h0);
        idle(L + 2);
        check("stream_cnt", 32'(got_d.size()), 32'h8);
        if (got_d.size() == 8) begin
            for (int i = 0; i < 8; i++) check("stream_data", 32'(got_d[i]), 32'(16'hA000 + i));
            check("stream_odd_addr", 32'(got_a[3]), 32'h0106);
`ifndef MEM_BLOCKING_EN
            for (int i = 1; i < 8; i++) check("stream_consec", 32'(got_e[i]), 32'(got_e[0] + i));
`endif
        end

        // Hazard ordering
        clear_log();
        req(1, 16'h0040, 16'h5555);
        req(0, 16'h0040, 16'h0);
        req(1, 16'h0040, 16'h6666);
        req(0, 16'h0040, 16'h0);
        idle(L + 2);
        check("hazard_cnt", 32'(got_d.size()), 32'h2);
        if (got_d.size() == 2) begin
            check("hazard_first", 32'(got_d[0]), 32'h5555);
            check("hazard_second", 32'(got_d[1]), 32'h6666);
        end

`ifdef MEM_BLOCKING_EN
        // Continuous reads: ready repeats 1,0,0,0
        enable = 1'b1; wr = 1'b0; addr = 16'h0020;
        for (int i = 0; i < 12; i++) begin
            check("blk_ready_pat", 32'(ready), 32'((i % 4) == 0));
            cycle();
        end
        idle(L + 2);
`endif

        // Randomized traffic over 16 prewritten words
        for (int k = 0; k < 16; k++) req(1, 16'(16'h0200 + 2 * k), 16'($urandom));
        idle(2);
        last_acc = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if (!enable || last_acc) begin
                enable  = ($urandom % 4) != 0;
                wr      = ($urandom % 3) == 0;
                addr    = 16'(16'h0200 + 2 * ($urandom % 16) + ($urandom % 2));
                data_in = 16'($urandom);
            end
            rst = ($urandom % 60) == 0;
            cycle();
        end
        rst = 1'b0;
        idle(L + 2);
        check("rand_queue_drained", 32'(q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
